// File: rtl/tinynpu_layer_seq_if.sv
// tinynpu_layer_seq_if: host-load, FIFO, MAC and result-port signals of the layer sequencer.
// With TINYNPU_PERF_EN defined, the perf_cycles / perf_mac counters are carried as well.
interface tinynpu_layer_seq_if #(
  parameter int unsigned SIZE       = 4,
  parameter int unsigned MAX_LAYERS = 8
);
  localparam int unsigned SELW = $clog2(SIZE);
  localparam int unsigned OSW  = $clog2(SIZE) + 1;
  localparam int unsigned LW   = $clog2(MAX_LAYERS) + 1;

  // Host / datapath status into the sequencer
  logic            start;
  logic [LW-1:0]   cfg_layers;
  logic            x_load_val;
  logic            w_load_val;
  logic [SELW-1:0] w_load_sel;
  logic            load_done;
  logic            x_fifo_empty;
  logic [SIZE-1:0] w_fifo_empty;
  logic            out_rdy;

  // Sequencer controls out to the datapath and host
  logic            x_sel;
  logic            x_fifo_wen;
  logic [SIZE-1:0] w_fifo_wen;
  logic            istream_val;
  logic            x_fifo_ren;
  logic            w_fifo_ren;
  logic            ostream_req;
  logic [OSW-1:0]  ostream_sel;
  logic            mac_rst;
  logic            z_out_sel;
  logic            out_val;
  logic            busy;
  logic            done;
  logic [LW-1:0]   layer_idx;
  logic [2:0]      trace_state;
`ifdef TINYNPU_PERF_EN
  logic [31:0]     perf_cycles;
  logic [31:0]     perf_mac;
`endif

  // Sequencer side
  modport master (
    input  start, cfg_layers, x_load_val, w_load_val, w_load_sel, load_done,
           x_fifo_empty, w_fifo_empty, out_rdy,
`ifdef TINYNPU_PERF_EN
    output perf_cycles, perf_mac,
`endif
    output x_sel, x_fifo_wen, w_fifo_wen, istream_val, x_fifo_ren, w_fifo_ren,
           ostream_req, ostream_sel, mac_rst, z_out_sel, out_val, busy, done,
           layer_idx, trace_state
  );

  // Host / datapath side
  modport slave (
    output start, cfg_layers, x_load_val, w_load_val, w_load_sel, load_done,
           x_fifo_empty, w_fifo_empty, out_rdy,
`ifdef TINYNPU_PERF_EN
    input  perf_cycles, perf_mac,
`endif
    input  x_sel, x_fifo_wen, w_fifo_wen, istream_val, x_fifo_ren, w_fifo_ren,
           ostream_req, ostream_sel, mac_rst, z_out_sel, out_val, busy, done,
           layer_idx, trace_state
  );
endinterface

// File: rtl/tinynpu_layer_seq.sv
// tinynpu_layer_seq: multi-layer LOAD -> MAC -> DRAIN -> FEED ... -> OUT sequencer for TinyNPU.
// Each non-final layer's MAC outputs are written back into the x FIFO as the next layer's input;
// after the final layer SIZE results leave through a valid/ready port.
// Optional macro TINYNPU_PERF_EN adds saturating perf_cycles / perf_mac counters.
module tinynpu_layer_seq #(
  parameter int unsigned SIZE       = 4,
  parameter int unsigned MAC_LAT    = 3,
  parameter int unsigned MAX_LAYERS = 8
) (
  input  logic                clk,
  input  logic                rst,
  tinynpu_layer_seq_if.master bus
);
  localparam int unsigned SELW = $clog2(SIZE);
  localparam int unsigned OSW  = $clog2(SIZE) + 1;
  localparam int unsigned LW   = $clog2(MAX_LAYERS) + 1;
  localparam int unsigned LATW = $clog2(MAC_LAT + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_MAC   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_FEED  = 3'd4;
  localparam logic [2:0] S_OUT   = 3'd5;

  logic [2:0]      state, state_nxt;
  logic [LW-1:0]   layer_idx_q, layer_idx_nxt;
  logic [LW-1:0]   layers_q, layers_nxt;
  logic [LATW-1:0] lat_cnt, lat_cnt_nxt;
  logic [OSW-1:0]  sel_cnt, sel_cnt_nxt;

  logic            empty_c;
  logic            start_acc_c;
  logic            last_layer_c;
  logic            lat_last_c;
  logic            sel_end_c;
  logic [LW-1:0]   cfg_clamped_c;

  logic            x_sel_c;
  logic            x_fifo_wen_c;
  logic [SIZE-1:0] w_fifo_wen_c;
  logic            istream_val_c;
  logic            ostream_req_c;
  logic            mac_rst_c;
  logic            z_out_sel_c;
  logic            out_val_c;
  logic            done_c;

  // Datapath is drained only when the x FIFO and every w lane are empty
  assign empty_c      = bus.x_fifo_empty & (&bus.w_fifo_empty);
  assign last_layer_c = (layer_idx_q >= (layers_q - LW'(1)));
  assign lat_last_c   = (lat_cnt == LATW'(MAC_LAT - 1));
  assign sel_end_c    = (sel_cnt == OSW'(SIZE));

  // Layer count: 0 means a single layer, anything above MAX_LAYERS saturates
  always_comb begin
    cfg_clamped_c = bus.cfg_layers;
    if (bus.cfg_layers == '0) begin
      cfg_clamped_c = LW'(1);
    end else if (bus.cfg_layers > LW'(MAX_LAYERS)) begin
      cfg_clamped_c = LW'(MAX_LAYERS);
    end
  end

  // Next-state and counter update logic
  always_comb begin
    state_nxt     = state;
    layer_idx_nxt = layer_idx_q;
    layers_nxt    = layers_q;
    lat_cnt_nxt   = lat_cnt;
    sel_cnt_nxt   = sel_cnt;
    start_acc_c   = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          start_acc_c   = 1'b1;
          state_nxt     = S_LOAD;
          layer_idx_nxt = '0;
          layers_nxt    = cfg_clamped_c;
          lat_cnt_nxt   = '0;
          sel_cnt_nxt   = '0;
        end
      end
      S_LOAD: begin
        if (bus.load_done) begin
          state_nxt = S_MAC;
        end
      end
      S_MAC: begin
        if (empty_c) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (lat_last_c) begin
          lat_cnt_nxt = '0;
          sel_cnt_nxt = '0;
          state_nxt   = last_layer_c ? S_OUT : S_FEED;
        end else begin
          lat_cnt_nxt = lat_cnt + LATW'(1);
        end
      end
      S_FEED: begin
        if (sel_end_c) begin
          sel_cnt_nxt   = '0;
          layer_idx_nxt = layer_idx_q + LW'(1);
          state_nxt     = S_LOAD;
        end else begin
          sel_cnt_nxt = sel_cnt + OSW'(1);
        end
      end
      S_OUT: begin
        if (sel_end_c) begin
          sel_cnt_nxt   = '0;
          layer_idx_nxt = '0;
          state_nxt     = S_IDLE;
        end else if (bus.out_rdy) begin
          sel_cnt_nxt = sel_cnt + OSW'(1);
        end
      end
      default: begin
        state_nxt     = S_IDLE;
        layer_idx_nxt = '0;
        layers_nxt    = '0;
        lat_cnt_nxt   = '0;
        sel_cnt_nxt   = '0;
      end
    endcase
  end

  // State and counter registers; reset abandons any job in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      layer_idx_q <= '0;
      layers_q    <= '0;
      lat_cnt     <= '0;
      sel_cnt     <= '0;
    end else begin
      state       <= state_nxt;
      layer_idx_q <= layer_idx_nxt;
      layers_q    <= layers_nxt;
      lat_cnt     <= lat_cnt_nxt;
      sel_cnt     <= sel_cnt_nxt;
    end
  end

  // Control outputs decoded from state and counters
  always_comb begin
    x_sel_c       = 1'b0;
    x_fifo_wen_c  = 1'b0;
    w_fifo_wen_c  = '0;
    istream_val_c = 1'b0;
    ostream_req_c = 1'b0;
    mac_rst_c     = 1'b0;
    z_out_sel_c   = 1'b0;
    out_val_c     = 1'b0;
    done_c        = 1'b0;
    case (state)
      S_LOAD: begin
        // Only the first layer takes x from the host; later layers use fed-back results
        x_fifo_wen_c = bus.x_load_val & (layer_idx_q == '0);
        for (int i = 0; i < int'(SIZE); i++) begin
          w_fifo_wen_c[i] = bus.w_load_val & (bus.w_load_sel == SELW'(i));
        end
      end
      S_MAC: begin
        istream_val_c = ~empty_c;
      end
      S_DRAIN: begin
        ostream_req_c = lat_last_c;
      end
      S_FEED: begin
        x_sel_c = 1'b1;
        if (sel_end_c) begin
          mac_rst_c = 1'b1;
        end else begin
          x_fifo_wen_c = 1'b1;
        end
      end
      S_OUT: begin
        z_out_sel_c = 1'b1;
        if (sel_end_c) begin
          mac_rst_c = 1'b1;
          done_c    = 1'b1;
        end else begin
          out_val_c = 1'b1;
        end
      end
      default: begin
        x_sel_c = 1'b0;
      end
    endcase
  end

  assign bus.x_sel       = x_sel_c;
  assign bus.x_fifo_wen  = x_fifo_wen_c;
  assign bus.w_fifo_wen  = w_fifo_wen_c;
  assign bus.istream_val = istream_val_c;
  assign bus.x_fifo_ren  = istream_val_c;
  assign bus.w_fifo_ren  = istream_val_c;
  assign bus.ostream_req = ostream_req_c;
  assign bus.ostream_sel = sel_cnt;
  assign bus.mac_rst     = mac_rst_c;
  assign bus.z_out_sel   = z_out_sel_c;
  assign bus.out_val     = out_val_c;
  assign bus.busy        = (state != S_IDLE);
  assign bus.done        = done_c;
  assign bus.layer_idx   = layer_idx_q;
  assign bus.trace_state = state;

`ifdef TINYNPU_PERF_EN
  logic [31:0] perf_cycles_q;
  logic [31:0] perf_mac_q;

  // Saturating job counters: cleared on start accept, held after done
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cycles_q <= '0;
      perf_mac_q    <= '0;
    end else if (start_acc_c) begin
      perf_cycles_q <= '0;
      perf_mac_q    <= '0;
    end else begin
      if ((state != S_IDLE) && (perf_cycles_q != '1)) begin
        perf_cycles_q <= perf_cycles_q + 32'd1;
      end
      if (istream_val_c && (perf_mac_q != '1)) begin
        perf_mac_q <= perf_mac_q + 32'd1;
      end
    end
  end

  assign bus.perf_cycles = perf_cycles_q;
  assign bus.perf_mac    = perf_mac_q;
`endif

endmodule
